// File: rtl/ip_stride_pq.sv
// IP-indexed stride prefetcher with confidence training and a queued valid/ready output.
// Define IP_STRIDE_PAGE_CROSS_EN to let bursts run past the 4 KiB page of the trigger.

module ip_stride_pq_entry #(
  parameter int ADDR_W = 64,
  parameter int TAG_W  = 58,
  parameter int CONF_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [TAG_W-1:0]  wtag,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [ADDR_W-1:0] wstride,
  input  logic [CONF_W-1:0] wconf,
  output logic              valid,
  output logic [TAG_W-1:0]  tag,
  output logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] stride,
  output logic [CONF_W-1:0] conf
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid     <= 1'b0;
      tag       <= '0;
      last_addr <= '0;
      stride    <= '0;
      conf      <= '0;
    end else if (we) begin
      valid     <= 1'b1;
      tag       <= wtag;
      last_addr <= waddr;
      stride    <= wstride;
      conf      <= wconf;
    end
  end
endmodule

module ip_stride_pq #(
  parameter int ADDR_W      = 64,
  parameter int IP_W        = 64,
  parameter int TRACKERS    = 64,
  parameter int DEGREE      = 4,
  parameter int CONF_W      = 2,
  parameter int CONF_THRESH = 2,
  parameter int QDEPTH      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              acc_valid_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [IP_W-1:0]   ip_i,
  input  logic [3:0]        degree_i,
  output logic              pref_valid_o,
  output logic [ADDR_W-1:0] pref_addr_o,
  input  logic              pref_ready_i,
  output logic              busy_o
);
  localparam int IDX_W = $clog2(TRACKERS);
  localparam int TAG_W = IP_W - IDX_W;
  localparam int QA_W  = $clog2(QDEPTH);
  localparam logic [CONF_W-1:0] THRESH = CONF_W'(CONF_THRESH);
  localparam logic [3:0]        DEG_MAX = 4'(DEGREE);

  typedef enum logic {IDLE, GEN} state_t;

  // ---------------- tracker table ----------------
  logic [IDX_W-1:0]                    idx;
  logic [TAG_W-1:0]                    tag_in;
  logic [TRACKERS-1:0]                 ent_valid;
  logic [TRACKERS-1:0][TAG_W-1:0]      ent_tag;
  logic [TRACKERS-1:0][ADDR_W-1:0]     ent_last;
  logic [TRACKERS-1:0][ADDR_W-1:0]     ent_stride;
  logic [TRACKERS-1:0][CONF_W-1:0]     ent_conf;

  logic              hit, match, trigger;
  logic [ADDR_W-1:0] d, wstride;
  logic [CONF_W-1:0] conf_cur, wconf;
  logic [3:0]        eff_deg;

  assign idx    = ip_i[IDX_W-1:0];
  assign tag_in = ip_i[IP_W-1:IDX_W];

  genvar i;
  generate
    for (i = 0; i < TRACKERS; i++) begin : g_ent
      ip_stride_pq_entry #(.ADDR_W(ADDR_W), .TAG_W(TAG_W), .CONF_W(CONF_W)) u_ent (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (acc_valid_i && (idx == IDX_W'(i))),
        .wtag     (tag_in),
        .waddr    (addr_i),
        .wstride  (wstride),
        .wconf    (wconf),
        .valid    (ent_valid[i]),
        .tag      (ent_tag[i]),
        .last_addr(ent_last[i]),
        .stride   (ent_stride[i]),
        .conf     (ent_conf[i])
      );
    end
  endgenerate

  assign conf_cur = ent_conf[idx];
  assign hit      = acc_valid_i && ent_valid[idx] && (ent_tag[idx] == tag_in);
  assign d        = addr_i - ent_last[idx];
  assign match    = hit && (d == ent_stride[idx]) && (d != '0);
  // On any hit the new stride equals d, whether it confirmed or replaced the old one.
  assign wstride  = hit ? d : '0;
  assign wconf    = !match ? '0 : (conf_cur == '1) ? conf_cur : conf_cur + 1'b1;
  assign eff_deg  = (degree_i > DEG_MAX) ? DEG_MAX : degree_i;
  assign trigger  = match && (wconf >= THRESH) && (eff_deg != 4'd0);

  // ---------------- output queue ----------------
  logic [QDEPTH-1:0][ADDR_W-1:0] q_mem;
  logic [QA_W-1:0]               wptr, rptr;
  logic [QA_W:0]                 cnt;
  logic                          q_full, push, pop;

  assign q_full = (cnt == (QA_W+1)'(QDEPTH));
  assign pop    = (cnt != '0) && pref_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
    end
  end

  // ---------------- generator ----------------
  state_t            state, state_d;
  logic [ADDR_W-1:0] cand, gstride;
  logic [3:0]        rem;
  logic              page_ok;

  always_ff @(posedge clk) begin
    if (push) q_mem[wptr] <= cand;
  end

  assign pref_valid_o = (cnt != '0);
  assign pref_addr_o  = pref_valid_o ? q_mem[rptr] : '0;
  assign busy_o       = (state != IDLE);

`ifdef IP_STRIDE_PAGE_CROSS_EN
  assign page_ok = 1'b1;
`else
  logic [ADDR_W-1:0] base;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       base <= '0;
    else if (trigger) base <= addr_i;
  end
  assign page_ok = (cand[ADDR_W-1:12] == base[ADDR_W-1:12]);
`endif

  // A trigger always wins: it reloads the burst and suppresses that cycle's push.
  always_comb begin
    state_d = state;
    push    = 1'b0;
    case (state)
      IDLE: if (trigger) state_d = GEN;
      GEN: begin
        if (trigger)      state_d = GEN;
        else if (!page_ok) state_d = IDLE;
        else if (!q_full) begin
          push = 1'b1;
          if (rem == 4'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cand    <= '0;
      gstride <= '0;
      rem     <= '0;
    end else begin
      state <= state_d;
      if (trigger) begin
        gstride <= d;
        cand    <= addr_i + d;
        rem     <= eff_deg;
      end else if (push) begin
        cand <= cand + gstride;
        rem  <= rem - 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_ip_stride_pq.sv
// Directed bench for ip_stride_pq: training, latency, page filter, backpressure, alias, retrigger, reset.
module tb_ip_stride_pq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        acc_valid_i = 1'b0;
  logic [63:0] addr_i = '0;
  logic [63:0] ip_i = '0;
  logic [3:0]  degree_i = 4'd4;
  logic        pref_valid_o;
  logic [63:0] pref_addr_o;
  logic        pref_ready_i = 1'b1;
  logic        busy_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] got_q[$];
  logic [63:0] exp_q[$];

  ip_stride_pq dut (
    .clk(clk), .rst_n(rst_n), .acc_valid_i(acc_valid_i), .addr_i(addr_i), .ip_i(ip_i),
    .degree_i(degree_i), .pref_valid_o(pref_valid_o), .pref_addr_o(pref_addr_o),
    .pref_ready_i(pref_ready_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Accepted prefetches: the handshake is stable mid-cycle and completes at the next rising edge.
  always @(negedge clk)
    if (rst_n && pref_valid_o && pref_ready_i) got_q.push_back(pref_addr_o);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_q(input string tag);
    chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++)
      chk($sformatf("%s_%0d", tag, k), (k < got_q.size()) ? got_q[k] : 64'hDEAD_DEAD, exp_q[k]);
  endtask

  task automatic acc(input logic [63:0] ip, input logic [63:0] a);
    ip_i = ip; addr_i = a; acc_valid_i = 1'b1;
    @(posedge clk); #1;
    acc_valid_i = 1'b0;
  endtask

  task automatic train(input logic [63:0] ip, input logic [63:0] a0, input logic [63:0] st);
    for (int k = 0; k < 4; k++) acc(ip, a0 + 64'(k) * st);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; acc_valid_i = 1'b0; pref_ready_i = 1'b1; degree_i = 4'd4;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    got_q.delete();
  endtask

  initial begin
    do_reset();
    chk("rst_valid", 64'(pref_valid_o), 64'd0);
    chk("rst_addr", pref_addr_o, 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);

    // Basic training and two-edge latency
    acc(64'h10, 64'h1000); acc(64'h10, 64'h1040); acc(64'h10, 64'h1080);
    chk("train_busy", 64'(busy_o), 64'd0);
    acc(64'h10, 64'h10C0);
    chk("trig_busy", 64'(busy_o), 64'd1);
    chk("trig_valid_e0", 64'(pref_valid_o), 64'd0);
    @(posedge clk); #1;
    chk("first_valid_e1", 64'(pref_valid_o), 64'd1);
    chk("first_addr_e1", pref_addr_o, 64'h1100);
    repeat (8) @(posedge clk); #1;
    exp_q = '{64'h1100, 64'h1140, 64'h1180, 64'h11C0};
    chk_q("basic");
    chk("basic_idle", 64'(busy_o), 64'd0);

    // Page crossing
    do_reset();
    train(64'h11, 64'h1E00, 64'h80);
    repeat (8) @(posedge clk); #1;
`ifdef IP_STRIDE_PAGE_CROSS_EN
    exp_q = '{64'h2000, 64'h2080, 64'h2100, 64'h2180};
`else
    exp_q = {};
`endif
    chk_q("page");
    chk("page_idle", 64'(busy_o), 64'd0);

    // Negative stride
    do_reset();
    train(64'h12, 64'h3000, -64'h40);
    repeat (8) @(posedge clk); #1;
    exp_q = '{64'h2F00, 64'h2EC0, 64'h2E80, 64'h2E40};
    chk_q("neg");

    // Runtime degree below DEGREE
    do_reset();
    degree_i = 4'd2;
    train(64'h17, 64'h8000, 64'h10);
    repeat (6) @(posedge clk); #1;
    exp_q = '{64'h8040, 64'h8050};
    chk_q("deg2");

    // Backpressure: fill to 8, third trigger held while full, then drain in order
    do_reset();
    pref_ready_i = 1'b0;
    train(64'h13, 64'h4000, 64'h40);
    repeat (5) @(posedge clk); #1;
    train(64'h14, 64'h5000, 64'h8);
    repeat (6) @(posedge clk); #1;
    chk("bp_valid", 64'(pref_valid_o), 64'd1);
    chk("bp_head", pref_addr_o, 64'h4100);
    chk("bp_idle_full", 64'(busy_o), 64'd0);
    acc(64'h13, 64'h4100);
    repeat (3) @(posedge clk); #1;
    chk("bp_hold_busy", 64'(busy_o), 64'd1);
    chk("bp_head_stable", pref_addr_o, 64'h4100);
    pref_ready_i = 1'b1;
    repeat (16) @(posedge clk); #1;
    exp_q = '{64'h4100, 64'h4140, 64'h4180, 64'h41C0, 64'h5020, 64'h5028, 64'h5030, 64'h5038,
              64'h4140, 64'h4180, 64'h41C0, 64'h4200};
    chk_q("bp");
    chk("bp_empty", 64'(pref_valid_o), 64'd0);

    // Alias on index 5: tag mismatch reallocates and resets confidence
    do_reset();
    acc(64'h05, 64'h6000); acc(64'h05, 64'h6040); acc(64'h05, 64'h6080);
    acc(64'h45, 64'h60C0);
    acc(64'h05, 64'h6100); acc(64'h05, 64'h6140); acc(64'h05, 64'h6180);
    repeat (6) @(posedge clk); #1;
    exp_q = {};
    chk_q("alias");
    chk("alias_busy", 64'(busy_o), 64'd0);

    // Retrigger after two pushes
    do_reset();
    pref_ready_i = 1'b0;
    train(64'h10, 64'h1000, 64'h40);
    repeat (2) @(posedge clk); #1;
    acc(64'h10, 64'h1100);
    repeat (6) @(posedge clk); #1;
    pref_ready_i = 1'b1;
    repeat (10) @(posedge clk); #1;
    exp_q = '{64'h1100, 64'h1140, 64'h1140, 64'h1180, 64'h11C0, 64'h1200};
    chk_q("retrig");

    // Asynchronous reset mid-burst
    do_reset();
    pref_ready_i = 1'b0;
    train(64'h16, 64'h7000, 64'h40);
    repeat (2) @(posedge clk); #3;
    chk("pre_rst_valid", 64'(pref_valid_o), 64'd1);
    rst_n = 1'b0; #1;
    chk("async_valid", 64'(pref_valid_o), 64'd0);
    chk("async_addr", pref_addr_o, 64'd0);
    chk("async_busy", 64'(busy_o), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    pref_ready_i = 1'b1;
    got_q.delete();
    acc(64'h16, 64'h7100);
    repeat (3) @(posedge clk); #1;
    acc(64'h16, 64'h7140);
    repeat (6) @(posedge clk); #1;
    exp_q = {};
    chk_q("post_rst");
    chk("post_rst_busy", 64'(busy_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
